// File: rtl/mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl
//
// Memory-mapped IO controller that sits beside data memory on the CPU
// load/store path. It decodes a small register window at BASE_ADDR. The
// window holds two LED banks, a 7-segment display word, two switch banks,
// a debounced button level vector and sticky button-press flags.
//
// Switch and button inputs are brought into the clk domain through 2-FF
// synchronisers. Each button then passes through its own debounce counter
// before it updates the accepted (stable) level. A 0->1 change of a stable
// level sets a sticky press flag. A valid read of BTN_EDGE clears all flags,
// but a flag that rises in that same cycle stays set.
//
// Word offsets from BASE_ADDR:
//    0x00 LED       RW     0x10 BTN_LEVEL RO
//    0x04 led       RW     0x14 BTN_EDGE  RO, read-to-clear
//    0x08 SWITCH    RO     0x18 IRQ_MASK  RW (only with MMIO_IRQ_EN)
//    0x0C switch    RO     0x20 seg       RW
//
// Any access that is misaligned, unmapped or a write to a read-only offset
// is rejected. A rejected access changes no state and returns zero. It
// raises addr_err for exactly the following cycle.
//
// Optional build macro: MMIO_IRQ_EN. When defined it adds the IRQ_MASK
// register and the irq output. irq = |(flags & mask), registered.
//
// Ports:
//    clk       in   system clock
//    rst       in   asynchronous, active-high reset
//    ioRead    in   IO read strobe from the controller
//    ioWrite   in   IO write strobe from the controller
//    addr_in   in   32-bit byte address from the ALU
//    din       in   32-bit store data from the register file
//    dout      out  32-bit load data (combinational, zero when no valid read)
//    SWITCH    in   big switch bank   [SW_W]
//    switch    in   little switch bank [SW_W]
//    button    in   raw push buttons, active high [NUM_BTN]
//    LED       out  big LED bank      [SW_W]
//    led       out  little LED bank   [SW_W]
//    seg       out  7-segment display word [32]
//    irq       out  button interrupt (MMIO_IRQ_EN builds only)
//    addr_err  out  one-cycle pulse after a rejected access
// ---------------------------------------------------------------------------
module mmio_io_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          SW_W      = 8,
   parameter int          NUM_BTN   = 4,
   parameter int          DB_CNT    = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ioRead,
   input  logic               ioWrite,
   input  logic [31:0]        addr_in,
   input  logic [31:0]        din,
   output logic [31:0]        dout,
   input  logic [SW_W-1:0]    SWITCH,
   input  logic [SW_W-1:0]    switch,
   input  logic [NUM_BTN-1:0] button,
   output logic [SW_W-1:0]    LED,
   output logic [SW_W-1:0]    led,
   output logic [31:0]        seg,
`ifdef MMIO_IRQ_EN
   output logic               irq,
`endif
   output logic               addr_err
);

   localparam int               CNT_W    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

   localparam logic [31:0] OFF_LED      = 32'h0000_0000;
   localparam logic [31:0] OFF_LED_LIT  = 32'h0000_0004;
   localparam logic [31:0] OFF_SW_BIG   = 32'h0000_0008;
   localparam logic [31:0] OFF_SW_LIT   = 32'h0000_000C;
   localparam logic [31:0] OFF_BTN_LVL  = 32'h0000_0010;
   localparam logic [31:0] OFF_BTN_EDGE = 32'h0000_0014;
   localparam logic [31:0] OFF_IRQ_MASK = 32'h0000_0018;
   localparam logic [31:0] OFF_SEG      = 32'h0000_0020;

   // Bus decode
   logic [31:0] off;
   logic        aligned;
   logic        mapped;
   logic        writable;
   logic        bad;
   logic        rd_ok;
   logic        wr_ok;
   logic        clr_edge;
   logic [31:0] rd_data;

   // Input synchronisers
   logic [SW_W-1:0]    sw_big_meta_q, sw_big_sync_q;
   logic [SW_W-1:0]    sw_lit_meta_q, sw_lit_sync_q;
   logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q;

   // Debounce and press flags
   logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic [NUM_BTN-1:0]            stable_q, stable_d;
   logic [NUM_BTN-1:0]            btn_edge_q, btn_edge_d;

   // Software-visible registers
   logic [SW_W-1:0] led_big_q, led_big_d;
   logic [SW_W-1:0] led_lit_q, led_lit_d;
   logic [31:0]     seg_q, seg_d;
   logic            addr_err_q, addr_err_d;
`ifdef MMIO_IRQ_EN
   logic [NUM_BTN-1:0] irq_mask_q, irq_mask_d;
   logic               irq_q, irq_d;
`endif

   // Address decode: classify the offset and qualify the strobes
   always_comb begin
      off      = addr_in - BASE_ADDR;
      aligned  = (addr_in[1:0] == 2'b00);
      mapped   = 1'b0;
      writable = 1'b0;
      case (off)
         OFF_LED, OFF_LED_LIT, OFF_SEG: begin
            mapped   = 1'b1;
            writable = 1'b1;
         end
         OFF_SW_BIG, OFF_SW_LIT, OFF_BTN_LVL, OFF_BTN_EDGE: begin
            mapped   = 1'b1;
            writable = 1'b0;
         end
`ifdef MMIO_IRQ_EN
         OFF_IRQ_MASK: begin
            mapped   = 1'b1;
            writable = 1'b1;
         end
`endif
         default: begin
            mapped   = 1'b0;
            writable = 1'b0;
         end
      endcase
      // A combined read+write is rejected as a whole if the write half is illegal.
      bad      = (ioRead | ioWrite) & (~aligned | ~mapped | (ioWrite & ~writable));
      rd_ok    = ioRead & ~bad;
      wr_ok    = ioWrite & ~bad;
      clr_edge = rd_ok & (off == OFF_BTN_EDGE);
   end

   // Read mux: current register values, so a same-cycle write returns pre-write data
   always_comb begin
      rd_data = 32'h0000_0000;
      case (off)
         OFF_LED:      rd_data = 32'(led_big_q);
         OFF_LED_LIT:  rd_data = 32'(led_lit_q);
         OFF_SW_BIG:   rd_data = 32'(sw_big_sync_q);
         OFF_SW_LIT:   rd_data = 32'(sw_lit_sync_q);
         OFF_BTN_LVL:  rd_data = 32'(stable_q);
         OFF_BTN_EDGE: rd_data = 32'(btn_edge_q);
`ifdef MMIO_IRQ_EN
         OFF_IRQ_MASK: rd_data = 32'(irq_mask_q);
`endif
         OFF_SEG:      rd_data = seg_q;
         default:      rd_data = 32'h0000_0000;
      endcase
      if (rd_ok) begin
         dout = rd_data;
      end else begin
         dout = 32'h0000_0000;
      end
   end

   // Register write next-state and address-error strobe
   always_comb begin
      led_big_d  = led_big_q;
      led_lit_d  = led_lit_q;
      seg_d      = seg_q;
`ifdef MMIO_IRQ_EN
      irq_mask_d = irq_mask_q;
`endif
      addr_err_d = bad;
      if (wr_ok) begin
         case (off)
            OFF_LED:      led_big_d  = din[SW_W-1:0];
            OFF_LED_LIT:  led_lit_d  = din[SW_W-1:0];
            OFF_SEG:      seg_d      = din;
`ifdef MMIO_IRQ_EN
            OFF_IRQ_MASK: irq_mask_d = din[NUM_BTN-1:0];
`endif
            default:      seg_d      = seg_q;
         endcase
      end else begin
         seg_d = seg_q;
      end
   end

   // Debounce: a level is accepted only after DB_CNT unbroken cycles of disagreement
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_sync_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == CNT_LAST) begin
            stable_d[i] = btn_sync_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
         end
      end
      // Clear first, then set, so a press coinciding with the clearing read survives.
      if (clr_edge) begin
         btn_edge_d = stable_d & ~stable_q;
      end else begin
         btn_edge_d = btn_edge_q | (stable_d & ~stable_q);
      end
   end

`ifdef MMIO_IRQ_EN
   // Interrupt next-state: follows the flags one cycle late, drops straight after a clearing read
   always_comb begin
      if (clr_edge) begin
         irq_d = 1'b0;
      end else begin
         irq_d = |(btn_edge_q & irq_mask_q);
      end
   end
`endif

   // Two-flop synchronisers for switches and buttons
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_big_meta_q <= '0;
         sw_big_sync_q <= '0;
         sw_lit_meta_q <= '0;
         sw_lit_sync_q <= '0;
         btn_meta_q    <= '0;
         btn_sync_q    <= '0;
      end else begin
         sw_big_meta_q <= SWITCH;
         sw_big_sync_q <= sw_big_meta_q;
         sw_lit_meta_q <= switch;
         sw_lit_sync_q <= sw_lit_meta_q;
         btn_meta_q    <= button;
         btn_sync_q    <= btn_meta_q;
      end
   end

   // Debounce counters, accepted levels and sticky press flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q   <= '0;
         stable_q   <= '0;
         btn_edge_q <= '0;
      end else begin
         db_cnt_q   <= db_cnt_d;
         stable_q   <= stable_d;
         btn_edge_q <= btn_edge_d;
      end
   end

   // Software-visible registers and the address-error strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_big_q  <= '0;
         led_lit_q  <= '0;
         seg_q      <= 32'h0000_0000;
         addr_err_q <= 1'b0;
`ifdef MMIO_IRQ_EN
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
`endif
      end else begin
         led_big_q  <= led_big_d;
         led_lit_q  <= led_lit_d;
         seg_q      <= seg_d;
         addr_err_q <= addr_err_d;
`ifdef MMIO_IRQ_EN
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
`endif
      end
   end

   assign LED      = led_big_q;
   assign led      = led_lit_q;
   assign seg      = seg_q;
   assign addr_err = addr_err_q;
`ifdef MMIO_IRQ_EN
   assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mmio_io_ctrl: directed scenarios followed by a randomized
// phase. The stimulus process pushes the expected dout of every read into a
// queue, and a monitor running on the falling edge pops and compares it.
// The monitor also checks LED/led/seg/addr_err against the reference model
// on every cycle. The model decides button levels from a per-cycle history
// of the raw inputs: a level is accepted once the raw input was constant
// for DB cycles, seen two cycles late through the synchroniser.
// ---------------------------------------------------------------------------
module tb_mmio_io_ctrl;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int SW_W = 8;
   localparam int NB   = 4;
   localparam int DB   = 16;
   localparam int HN   = 8192;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ioRead = 1'b0, ioWrite = 1'b0;
   logic [31:0]       addr_in = 32'h0, din = 32'h0;
   logic [31:0]       dout;
   logic [SW_W-1:0]   SWITCH = '0, switch = '0;
   logic [NB-1:0]     button = '0;
   logic [SW_W-1:0]   LED, led;
   logic [31:0]       seg;
   logic              addr_err;
`ifdef MMIO_IRQ_EN
   logic              irq;
`endif

   mmio_io_ctrl #(.BASE_ADDR(BASE), .SW_W(SW_W), .NUM_BTN(NB), .DB_CNT(DB)) dut (
      .clk(clk), .rst(rst), .ioRead(ioRead), .ioWrite(ioWrite),
      .addr_in(addr_in), .din(din), .dout(dout),
      .SWITCH(SWITCH), .switch(switch), .button(button),
      .LED(LED), .led(led), .seg(seg),
`ifdef MMIO_IRQ_EN
      .irq(irq),
`endif
      .addr_err(addr_err));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   // Reference model state
   logic [SW_W-1:0] m_led_big = '0, m_led_lit = '0;
   logic [31:0]     m_seg = 32'h0;
   logic [NB-1:0]   m_stable = '0, m_flags = '0;
   logic            m_err = 1'b0;
`ifdef MMIO_IRQ_EN
   logic [NB-1:0]   m_mask = '0;
   logic            m_irq = 1'b0;
`endif
   logic [NB-1:0]   raw_hist [HN];
   logic [SW_W-1:0] swb_hist [HN];
   logic [SW_W-1:0] swl_hist [HN];
   int              cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic is_mapped(input logic [31:0] o);
      logic m;
      m = (o == 32'h0) || (o == 32'h4) || (o == 32'h8) || (o == 32'hC) ||
          (o == 32'h10) || (o == 32'h14) || (o == 32'h20);
`ifdef MMIO_IRQ_EN
      m = m || (o == 32'h18);
`endif
      return m;
   endfunction

   function automatic logic is_writable(input logic [31:0] o);
      logic w;
      w = (o == 32'h0) || (o == 32'h4) || (o == 32'h20);
`ifdef MMIO_IRQ_EN
      w = w || (o == 32'h18);
`endif
      return w;
   endfunction

   function automatic logic access_bad(input logic rd, input logic wr, input logic [31:0] a);
      if (!(rd || wr)) return 1'b0;
      if (a[1:0] != 2'b00) return 1'b1;
      if (!is_mapped(a - BASE)) return 1'b1;
      if (wr && !is_writable(a - BASE)) return 1'b1;
      return 1'b0;
   endfunction

   // Value a read returns now; switch reads see the input of two edges ago
   function automatic logic [31:0] read_val(input logic [31:0] o);
      case (o)
         32'h00: return 32'(m_led_big);
         32'h04: return 32'(m_led_lit);
         32'h08: return 32'(swb_hist[13'(cyc - 2)]);
         32'h0C: return 32'(swl_hist[13'(cyc - 2)]);
         32'h10: return 32'(m_stable);
         32'h14: return 32'(m_flags);
`ifdef MMIO_IRQ_EN
         32'h18: return 32'(m_mask);
`endif
         32'h20: return m_seg;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] exp_dout(input logic wr, input logic [31:0] a);
      if (access_bad(1'b1, wr, a)) return 32'h0;
      return read_val(a - BASE);
   endfunction

   // Accepted level after edge c: raw samples c-1-DB .. c-2 all equal and different from now
   function automatic logic [NB-1:0] next_stable(input int c, input logic [NB-1:0] st);
      logic [NB-1:0] ns;
      logic          v, same;
      ns = st;
      if (c - 1 - DB >= 0) begin
         for (int i = 0; i < NB; i++) begin
            v    = raw_hist[13'(c - 2)][i];
            same = 1'b1;
            for (int k = c - 1 - DB; k <= c - 2; k++)
               if (raw_hist[13'(k)][i] != v) same = 1'b0;
            if (same && (v != st[i])) ns[i] = v;
         end
      end
      return ns;
   endfunction

   function automatic logic clr_now();
      return ioRead && !access_bad(ioRead, ioWrite, addr_in) && ((addr_in - BASE) == 32'h14);
   endfunction

   // Raw input history, one entry per clock edge (zero while in reset)
   always @(posedge clk) begin
      raw_hist[13'(cyc)] <= rst ? '0 : button;
      swb_hist[13'(cyc)] <= rst ? '0 : SWITCH;
      swl_hist[13'(cyc)] <= rst ? '0 : switch;
      cyc <= cyc + 1;
   end

   // Reference model register updates
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_led_big <= '0; m_led_lit <= '0; m_seg <= 32'h0;
         m_stable  <= '0; m_flags   <= '0; m_err <= 1'b0;
`ifdef MMIO_IRQ_EN
         m_mask <= '0; m_irq <= 1'b0;
`endif
      end else begin
         m_stable <= next_stable(cyc, m_stable);
         m_flags  <= (clr_now() ? '0 : m_flags) | (next_stable(cyc, m_stable) & ~m_stable);
         m_err    <= access_bad(ioRead, ioWrite, addr_in);
`ifdef MMIO_IRQ_EN
         m_irq    <= (|(m_flags & m_mask)) && !clr_now();
`endif
         if (ioWrite && !access_bad(ioRead, ioWrite, addr_in)) begin
            case (addr_in - BASE)
               32'h00: m_led_big <= din[SW_W-1:0];
               32'h04: m_led_lit <= din[SW_W-1:0];
               32'h20: m_seg     <= din;
`ifdef MMIO_IRQ_EN
               32'h18: m_mask    <= din[NB-1:0];
`endif
               default: m_seg    <= m_seg;
            endcase
         end
      end
   end

   // Monitor: compare outputs against the model and pop expected read data
   always @(negedge clk) begin
      check("LED", 32'(LED), 32'(m_led_big));
      check("led", 32'(led), 32'(m_led_lit));
      check("seg", seg, m_seg);
      check("addr_err", 32'(addr_err), 32'(m_err));
`ifdef MMIO_IRQ_EN
      check("irq", 32'(irq), 32'(m_irq));
`endif
      if (ioRead) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dout_noexp: read at %0t has no expected value", $time);
         end else begin
            check("dout", dout, exp_q.pop_front());
         end
      end
   end

   // One bus cycle; called at posedge+1, returns at the next posedge+1
   task automatic access(input logic rd, input logic wr, input logic [31:0] o,
                         input logic [31:0] data, output logic [31:0] got);
      ioRead  = rd;
      ioWrite = wr;
      addr_in = BASE + o;
      din     = data;
      if (rd) exp_q.push_back(exp_dout(wr, BASE + o));
      #1 got = dout;
      @(posedge clk);
      #1;
      ioRead  = 1'b0;
      ioWrite = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] offs [11];
      int          r;
      offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h20, 32'h30, 32'h2, 32'h24};
      SWITCH = 8'hA5;
      switch = 8'h3C;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_LED", 32'(LED), 32'h0);
      access(1'b1, 1'b0, 32'h10, 32'h0, got); check("rst_level", got, 32'h0);
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("rst_edge", got, 32'h0);
      access(1'b1, 1'b0, 32'h08, 32'h0, got); check("sw_big", got, 32'h0000_00A5);
      access(1'b1, 1'b0, 32'h0C, 32'h0, got); check("sw_lit", got, 32'h0000_003C);

      // LED write/read and read+write of seg
      access(1'b0, 1'b1, 32'h00, 32'h0000_005A, got);
      check("led_big_wr", 32'(LED), 32'h5A);
      check("led_lit_keep", 32'(led), 32'h0);
      access(1'b1, 1'b0, 32'h00, 32'h0, got); check("led_rd", got, 32'h0000_005A);
      access(1'b1, 1'b1, 32'h20, 32'h0000_1234, got); check("seg_rw_pre", got, 32'h0);
      check("seg_after", seg, 32'h0000_1234);

      // Bounce on button[0]: toggles every 5 cycles, level must not move
      for (int s = 0; s < 8; s++) begin
         button[0] = (s % 2 == 0);
         for (int j = 0; j < 5; j++) begin
            access(1'b1, 1'b0, 32'h10, 32'h0, got);
            check("bounce_lvl", 32'(got[0]), 32'h0);
         end
      end
      // Final rise: level becomes 1 exactly DB+2 edges later
      button[0] = 1'b1;
      for (int i = 0; i < 22; i++) begin
         access(1'b1, 1'b0, 32'h10, 32'h0, got);
         check("lvl_timing", 32'(got[0]), 32'(i >= DB + 2));
      end

      // Press flags: read-to-clear, then a rise coinciding with the clearing read
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("edge_first", got, 32'h1);
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("edge_cleared", got, 32'h0);
      button[1] = 1'b1;
      repeat (DB + 1) access(1'b0, 1'b0, 32'h0, 32'h0, got);
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("edge_coincide_rd", got, 32'h0);
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("edge_set_wins", got, 32'h2);
      access(1'b1, 1'b0, 32'h10, 32'h0, got); check("lvl_two", got, 32'h3);

      // Rejected accesses
      access(1'b0, 1'b1, 32'h30, 32'hFFFF_FFFF, got); check("err_unmapped", 32'(addr_err), 32'h1);
      access(1'b0, 1'b1, 32'h02, 32'hFFFF_FFFF, got); check("err_misalign", 32'(addr_err), 32'h1);
      access(1'b0, 1'b1, 32'h08, 32'hFFFF_FFFF, got); check("err_ro", 32'(addr_err), 32'h1);
      access(1'b1, 1'b0, 32'h30, 32'h0, got);         check("err_rd_dout", got, 32'h0);
      access(1'b0, 1'b0, 32'h00, 32'h0, got);         check("err_drop", 32'(addr_err), 32'h0);
      check("err_no_change", 32'(LED), 32'h5A);
      access(1'b1, 1'b1, 32'h14, 32'h0, got);         check("err_rw_ro", got, 32'h0);

      // Reset mid-operation with LED set and a button mid-debounce
      access(1'b0, 1'b1, 32'h00, 32'h0000_00FF, got);
      button[2] = 1'b1;
      repeat (8) access(1'b0, 1'b0, 32'h0, 32'h0, got);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      button = '0;
      rst = 1'b0;
      check("rst2_LED", 32'(LED), 32'h0);
      check("rst2_seg", seg, 32'h0);
      access(1'b1, 1'b0, 32'h10, 32'h0, got); check("rst2_level", got, 32'h0);
      access(1'b1, 1'b0, 32'h14, 32'h0, got); check("rst2_edge", got, 32'h0);

      // Randomized phase
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) == 0) SWITCH = SW_W'($urandom);
         if ($urandom_range(0, 9) == 0) switch = SW_W'($urandom);
         for (int b = 0; b < NB; b++)
            if ($urandom_range(0, 29) == 0) button[b] = ~button[b];
         r = $urandom_range(0, 9);
         begin
            logic [31:0] o;
            o = ($urandom_range(0, 19) == 0) ? $urandom : offs[$urandom_range(0, 10)];
            if (r <= 3)      access(1'b1, 1'b0, o, $urandom, got);
            else if (r <= 6) access(1'b0, 1'b1, o, $urandom, got);
            else if (r == 7) access(1'b1, 1'b1, o, $urandom, got);
            else             access(1'b0, 1'b0, o, $urandom, got);
         end
      end
      repeat (2) access(1'b0, 1'b0, 32'h0, 32'h0, got);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Parametrised memory-mapped IO controller. It replaces the fixed-width LED/switch/button/7-seg decoder that sits beside data memory on the CPU load/store path.
- Adds 2-FF input synchronisers and per-button debounce counters.
- Adds sticky button-press flags that clear on read, LED/seg read-back, and an address-error strobe.
- Driven by the Controller's ioRead/ioWrite and the ALU address; read data goes to the register-file write mux.

Parameters:
BASE_ADDR, 32'hFFFF0000, base of the IO window; all offsets below are relative to it
SW_W, 8, width of each switch bank and each LED bank (1..32)
NUM_BTN, 4, number of push buttons (1..32)
DB_CNT, 100000, cycles a synchronised button level must stay constant before it is accepted (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ioRead  in  1  IO read strobe from Controller
ioWrite  in  1  IO write strobe from Controller
addr_in  in  32  byte address from ALUResult
din  in  32  store data from register file
dout  out  32  load data to register-file write mux
SWITCH  in  SW_W  big switch bank
switch  in  SW_W  little switch bank
button  in  NUM_BTN  raw push buttons, active high
LED  out  SW_W  big LED bank
led  out  SW_W  little LED bank
seg  out  32  7-seg display word
addr_err  out  1  one-cycle pulse on a bad IO access

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: LED, led, seg, addr_err = 0. Synchronisers, debounce counters, stable levels and edge flags = 0. An in-progress debounce is discarded.
- Address map (word offsets, RO = read-only):
  - 0x00 LED (RW)
  - 0x04 led (RW)
  - 0x08 SWITCH (RO)
  - 0x0C switch (RO)
  - 0x10 BTN_LEVEL, debounced level vector (RO)
  - 0x14 BTN_EDGE, sticky press flags (RO, read-to-clear)
  - 0x20 seg (RW)
- Read data is zero-extended to 32 bits.
- Access is valid only when addr_in[1:0]==0 and the offset is mapped.
- Reads:
  - dout is combinational and valid in the same cycle as ioRead.
  - dout = 0 when ioRead=0 or the access is invalid.
- Writes:
  - Take effect on the clk edge ending the ioWrite cycle; visible the next cycle.
  - Writes to RO offsets are ignored and raise addr_err.
  - LED and led take din[SW_W-1:0]; seg takes din[31:0].
- ioRead and ioWrite together:
  - The write is performed; dout returns the pre-write value.
  - Invalid when either access would be invalid.
- addr_err: registered. It is 1 for exactly the cycle after an invalid access, with no state change.
- Switches: 2-FF synchronised; reads return the synchronised value (2-cycle input latency).
- Debounce, per button:
  - 2-FF sync, then counter cnt.
  - If sync == stable: cnt <= 0.
  - Else if cnt == DB_CNT-1: stable <= sync and cnt <= 0.
  - Else: cnt++.
  - Net latency from a clean input edge to a stable change is 2+DB_CNT cycles.
  - Any bounce restarts the count.
- Edge flags:
  - A 0->1 transition of stable[i] sets edge[i].
  - A valid read of BTN_EDGE clears all flags at the end of that cycle.
  - Set wins: a flag whose rising edge coincides with the clearing read stays 1.
  - A read of any other address does not clear flags.

Optional Feature:
Macro MMIO_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and register IRQ_MASK at offset 0x18 (RW, NUM_BTN bits, reset 0).
  - irq = |(edge & IRQ_MASK), registered; it rises 1 cycle after the flag sets.
  - irq drops the cycle after the clearing read.
- Undefined:
  - No irq port.
  - 0x18 is unmapped; access to it raises addr_err.

Test Plan:
- rst=1 mid-operation with LED=0xFF and a button mid-debounce -> LED/led/seg=0, BTN_LEVEL=0 and BTN_EDGE=0 after release.
- ioWrite to 0x00 with din=0x5A -> LED=0x5A next cycle, led unchanged; ioRead of 0x00 returns 0x0000005A; ioWrite plus ioRead of 0x20 with din=0x1234 -> dout=0 that cycle, seg=0x1234 after.
- DB_CNT=16, button[0] toggles every 5 cycles for 40 cycles then held high -> BTN_LEVEL bit0 stays 0 during bounce and reads 1 exactly 18 cycles after the final rise.
- After a button[0] press, read 0x14 -> 0x1, a second read -> 0x0; a button[1] stable rise in the same cycle as a clearing read -> next read returns 0x2.
- ioWrite to 0x30 or 0x02, or to 0x08 -> addr_err=1 for one cycle, no register changes, dout=0 on a read of 0x30.
- With MMIO_IRQ_EN and IRQ_MASK=0x1: press button[1] -> irq stays 0; press button[0] -> irq=1; read 0x14 -> irq=0 next cycle.
